// File: rtl/mem_stage.sv
// Memory-access stage: pass-through for ALU ops, req/ack data-bus transaction for loads/stores.
// Latency: pass-through is combinational; loads/stores take IDLE+WAIT(>=1)+DONE, stalling upstream until DONE.
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_memaddr,
    input  logic [31:0] ex_reg2,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        stallreq_mem,
    output logic        mem_misalign,
    output logic        mem_buserr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_sel,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [3:0]       sel_q;
    logic [31:0]      wdata_q;
    logic             we_q;
    logic [3:0]       op_q;
    logic [1:0]       off_q;
    logic [31:0]      result_q;
    logic             buserr_q;

    logic        is_load, is_store, is_mem, misalign;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c;
    logic [31:0] load_ext;

    always_comb begin
        is_load  = (ex_memop >= OP_LB) && (ex_memop <= OP_LHU);
        is_store = (ex_memop >= OP_SB) && (ex_memop <= OP_SW);
        is_mem   = is_load || is_store;
        misalign = ((ex_memop == OP_LH || ex_memop == OP_LHU || ex_memop == OP_SH) && ex_memaddr[0]) ||
                   ((ex_memop == OP_LW || ex_memop == OP_SW) && (ex_memaddr[1:0] != 2'b00));
        sel_c   = 4'b0000;
        wdata_c = ex_reg2;
        case (ex_memop)
            OP_LB, OP_LBU, OP_SB: begin
                sel_c   = 4'b0001 << ex_memaddr[1:0];
                wdata_c = {4{ex_reg2[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                sel_c   = ex_memaddr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{ex_reg2[15:0]}};
            end
            OP_LW, OP_SW: sel_c = 4'b1111;
            default: ;
        endcase
    end

    // Extraction uses the latched op and byte offset so it matches the request actually issued.
    always_comb begin
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v   = dmem_rdata[8*off_q +: 8];
        half_v   = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_ext = dmem_rdata;
        case (op_q)
            OP_LB:   load_ext = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_ext = {24'b0, byte_v};
            OP_LH:   load_ext = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_ext = {16'b0, half_v};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            sel_q    <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            op_q     <= '0;
            off_q    <= '0;
            result_q <= '0;
            buserr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_mem && !misalign) begin
                        addr_q   <= {ex_memaddr[31:2], 2'b00};
                        sel_q    <= sel_c;
                        wdata_q  <= wdata_c;
                        we_q     <= is_store;
                        op_q     <= ex_memop;
                        off_q    <= ex_memaddr[1:0];
                        cnt_q    <= '0;
                        result_q <= '0;
                        buserr_q <= 1'b0;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        if (!we_q) result_q <= load_ext;
                        state_q <= S_DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        buserr_q <= 1'b1;
                        result_q <= '0;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs are gated by rst so an asserted reset clears everything, including the pass-through path.
    always_comb begin
        mem_wd       = 5'd0;
        mem_wreg     = 1'b0;
        mem_wdata    = 32'd0;
        stallreq_mem = 1'b0;
        mem_misalign = 1'b0;
        mem_buserr   = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = 32'd0;
        dmem_sel     = 4'd0;
        dmem_wdata   = 32'd0;
        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    mem_wd = ex_wd;
                    if (!is_mem) begin
                        mem_wreg  = ex_wreg;
                        mem_wdata = ex_wdata;
                    end else if (misalign) begin
                        mem_misalign = 1'b1;
                    end else begin
                        stallreq_mem = 1'b1;
                        dmem_req     = 1'b1;
                        dmem_we      = is_store;
                        dmem_addr    = {ex_memaddr[31:2], 2'b00};
                        dmem_sel     = sel_c;
                        dmem_wdata   = wdata_c;
                    end
                end
                S_WAIT: begin
                    mem_wd       = ex_wd;
                    stallreq_mem = 1'b1;
                    dmem_req     = 1'b1;
                    dmem_we      = we_q;
                    dmem_addr    = addr_q;
                    dmem_sel     = sel_q;
                    dmem_wdata   = wdata_q;
                end
                S_DONE: begin
                    mem_wd     = ex_wd;
                    mem_wreg   = ex_wreg && !we_q && !buserr_q;
                    mem_wdata  = result_q;
                    mem_buserr = buserr_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads/stores, misalignment, timeout and async reset.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_memop;
    logic [31:0] ex_memaddr;
    logic [31:0] ex_reg2;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stallreq_mem;
    logic        mem_misalign;
    logic        mem_buserr;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_sel;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    int errors = 0;
    int checks = 0;
    int n_stall;

    mem_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_memop(ex_memop),
        .ex_memaddr(ex_memaddr), .ex_reg2(ex_reg2),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .stallreq_mem(stallreq_mem), .mem_misalign(mem_misalign), .mem_buserr(mem_buserr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_sel(dmem_sel),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; ex_wd = 5'd0; ex_wreg = 1'b0; ex_wdata = 32'd0; ex_memop = 4'd0;
        ex_memaddr = 32'd0; ex_reg2 = 32'd0; dmem_rdata = 32'd0; dmem_ack = 1'b0;
        #2;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stallreq_mem), 32'd0);
        ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234;
        #1;
        chk("rst_wreg", 32'(mem_wreg), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wd", 32'(mem_wd), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc();

        // ALU pass-through
        #1;
        chk("pt_wd", 32'(mem_wd), 32'd5);
        chk("pt_wreg", 32'(mem_wreg), 32'd1);
        chk("pt_wdata", mem_wdata, 32'h1234);
        chk("pt_stall", 32'(stallreq_mem), 32'd0);
        chk("pt_req", 32'(dmem_req), 32'd0);

        // LB at byte 3, ack on second WAIT cycle
        ex_wd = 5'd7; ex_memop = 4'd1; ex_memaddr = 32'h1003;
        #1;
        chk("lb_idle_req", 32'(dmem_req), 32'd1);
        chk("lb_idle_stall", 32'(stallreq_mem), 32'd1);
        chk("lb_sel", 32'(dmem_sel), 32'h8);
        chk("lb_we", 32'(dmem_we), 32'd0);
        chk("lb_addr", dmem_addr, 32'h1000);
        cyc();
        chk("lb_w1_stall", 32'(stallreq_mem), 32'd1);
        chk("lb_w1_sel", 32'(dmem_sel), 32'h8);
        cyc();
        dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FFFF;
        #1;
        chk("lb_w2_stall", 32'(stallreq_mem), 32'd1);
        cyc();
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        #1;
        chk("lb_done_stall", 32'(stallreq_mem), 32'd0);
        chk("lb_done_req", 32'(dmem_req), 32'd0);
        chk("lb_done_wdata", mem_wdata, 32'hFFFF_FF80);
        chk("lb_done_wreg", 32'(mem_wreg), 32'd1);
        chk("lb_done_wd", 32'(mem_wd), 32'd7);
        ex_memop = 4'd0;
        cyc();
        chk("lb_back_idle", 32'(stallreq_mem), 32'd0);

        // LBU, same stimulus
        ex_memop = 4'd4;
        cyc();
        cyc();
        dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FFFF;
        cyc();
        dmem_ack = 1'b0;
        #1;
        chk("lbu_done_wdata", mem_wdata, 32'h0000_0080);
        ex_memop = 4'd0;
        cyc();

        // SH upper half with immediate ack; upstream change must not reach the bus
        ex_memop = 4'd7; ex_memaddr = 32'h2002; ex_reg2 = 32'hAABB_CCDD;
        #1;
        chk("sh_we", 32'(dmem_we), 32'd1);
        chk("sh_sel", 32'(dmem_sel), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hCCDD_CCDD);
        chk("sh_addr", dmem_addr, 32'h2000);
        cyc();
        dmem_ack = 1'b1; ex_reg2 = 32'h0;
        #1;
        chk("sh_wait_wdata_held", dmem_wdata, 32'hCCDD_CCDD);
        chk("sh_wait_we", 32'(dmem_we), 32'd1);
        cyc();
        dmem_ack = 1'b0;
        #1;
        chk("sh_done_wreg", 32'(mem_wreg), 32'd0);
        chk("sh_done_stall", 32'(stallreq_mem), 32'd0);
        ex_memop = 4'd0;
        cyc();

        // SB at byte 1
        ex_memop = 4'd6; ex_memaddr = 32'h2401; ex_reg2 = 32'h1234_5678;
        #1;
        chk("sb_sel", 32'(dmem_sel), 32'h2);
        chk("sb_wdata", dmem_wdata, 32'h7878_7878);
        cyc();
        dmem_ack = 1'b1;
        cyc();
        dmem_ack = 1'b0; ex_memop = 4'd0;
        cyc();

        // LH upper half, sign-extended
        ex_memop = 4'd2; ex_memaddr = 32'h2802;
        #1;
        chk("lh_sel", 32'(dmem_sel), 32'hC);
        cyc();
        dmem_ack = 1'b1; dmem_rdata = 32'h8001_1234;
        cyc();
        dmem_ack = 1'b0;
        #1;
        chk("lh_done_wdata", mem_wdata, 32'hFFFF_8001);
        ex_memop = 4'd0;
        cyc();

        // Misaligned LW
        ex_memop = 4'd3; ex_memaddr = 32'h3001;
        #1;
        chk("mis_flag", 32'(mem_misalign), 32'd1);
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_stall", 32'(stallreq_mem), 32'd0);
        chk("mis_wreg", 32'(mem_wreg), 32'd0);
        cyc();
        ex_memop = 4'd0;
        #1;
        chk("mis_flag_clr", 32'(mem_misalign), 32'd0);

        // LW timeout: count stalled cycles including the IDLE request cycle
        ex_memop = 4'd3; ex_memaddr = 32'h4000;
        #1;
        n_stall = stallreq_mem ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (!stallreq_mem) break;
            n_stall++;
        end
        chk("to_stall_cycles", 32'(n_stall), 32'd17);
        chk("to_buserr", 32'(mem_buserr), 32'd1);
        chk("to_wreg", 32'(mem_wreg), 32'd0);
        chk("to_wdata", mem_wdata, 32'd0);
        ex_memop = 4'd0;
        cyc();
        chk("to_buserr_clr", 32'(mem_buserr), 32'd0);
        chk("to_idle_pt", mem_wdata, 32'h1234);

        // Async reset mid-WAIT
        ex_memop = 4'd3; ex_memaddr = 32'h5000;
        cyc();
        cyc();
        chk("ar_wait_req", 32'(dmem_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_req_drop", 32'(dmem_req), 32'd0);
        chk("ar_stall_drop", 32'(stallreq_mem), 32'd0);
        ex_memop = 4'd0;
        @(negedge clk);
        rst = 1'b1;
        cyc();
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ar_ack_req", 32'(dmem_req), 32'd0);
        chk("ar_ack_stall", 32'(stallreq_mem), 32'd0);
        cyc();
        dmem_ack = 1'b0;
        #1;
        chk("ar_after_wdata", mem_wdata, 32'h1234);
        chk("ar_after_wreg", 32'(mem_wreg), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
